// File: rtl/pred_ctrl_pkg.sv
// Shared types and helpers for the tournament predictor controller:
// FSM state encoding, chooser level names and the chooser update rule.
package pred_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } pred_state_e;

  // Chooser levels: bit 1 selects Z, bit 0 is the confidence within a side.
  localparam logic [1:0] CH_STRONG_Y = 2'd0;
  localparam logic [1:0] CH_WEAK_Y   = 2'd1;
  localparam logic [1:0] CH_WEAK_Z   = 2'd2;
  localparam logic [1:0] CH_STRONG_Z = 2'd3;

  // Move toward whichever predictor alone was right; hold on agreement.
  function automatic logic [1:0] chooser_next(input logic [1:0] cur,
                                              input logic       y_ok,
                                              input logic       z_ok);
    logic [1:0] nxt;
    nxt = cur;
    if (y_ok && !z_ok) begin
      if (cur != CH_STRONG_Y) nxt = cur - 2'd1;
    end else if (z_ok && !y_ok) begin
      if (cur != CH_STRONG_Z) nxt = cur + 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pred_tournament_ctrl_if.sv
// Bundle between the outcome source (master) and the tournament controller
// (slave). There is no ready: a sample is consumed on any clock edge where
// x_valid is high and the controller is in WARM or RUN; in IDLE/DONE it is
// dropped, and a start in the same cycle wins over x_valid.
// Optional disagree_cnt exists only when PRED_CTRL_DISAGREE_CNT_EN is defined.
interface pred_tournament_ctrl_if #(
  parameter int CNT_W = 8
);
  import pred_ctrl_pkg::*;

  logic             start;
  logic             x_valid;
  logic             x;
  logic             y_pred;
  logic             z_pred;
  logic             pred_out;
  logic             sel_z;
  logic [1:0]       chooser;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] y_cnt;
  logic [CNT_W-1:0] z_cnt;
  logic [CNT_W-1:0] t_cnt;
  logic [CNT_W-1:0] sample_cnt;
`ifdef PRED_CTRL_DISAGREE_CNT_EN
  logic [CNT_W-1:0] disagree_cnt;
`endif
  pred_state_e      state;

  modport master (
    output start, x_valid, x, y_pred, z_pred,
    input  pred_out, sel_z, chooser, busy, done,
    input  y_cnt, z_cnt, t_cnt, sample_cnt,
`ifdef PRED_CTRL_DISAGREE_CNT_EN
    input  disagree_cnt,
`endif
    input  state
  );

  modport slave (
    input  start, x_valid, x, y_pred, z_pred,
    output pred_out, sel_z, chooser, busy, done,
    output y_cnt, z_cnt, t_cnt, sample_cnt,
`ifdef PRED_CTRL_DISAGREE_CNT_EN
    output disagree_cnt,
`endif
    output state
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Count register: async clear on reset, sync clear, saturating increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pred_tournament_ctrl.sv
// Tournament controller for two predictors Y and Z watching one outcome
// stream. Runs epochs of EPOCH_LEN samples, the first WARMUP of which only
// advance the sample count; the rest score both predictors, the chosen
// prediction, and train a 2-bit chooser.
// Optional feature macro: PRED_CTRL_DISAGREE_CNT_EN adds disagree_cnt.
module pred_tournament_ctrl
  import pred_ctrl_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int EPOCH_LEN    = 36,
  parameter int WARMUP       = 4,
  parameter int CHOOSER_INIT = 1
) (
  input logic                   clk,
  input logic                   reset,
  pred_tournament_ctrl_if.slave bus
);

  if (EPOCH_LEN >= (1 << CNT_W)) begin : g_bad_epoch_len
    $error("EPOCH_LEN must be below 2**CNT_W");
  end
  if (WARMUP >= EPOCH_LEN) begin : g_bad_warmup
    $error("WARMUP must be below EPOCH_LEN");
  end
  if ((CHOOSER_INIT < 0) || (CHOOSER_INIT > 3)) begin : g_bad_chooser_init
    $error("CHOOSER_INIT must be 0..3");
  end

  localparam logic [CNT_W-1:0] EPOCH_LEN_C = CNT_W'(EPOCH_LEN);
  localparam logic [CNT_W-1:0] WARMUP_C    = CNT_W'(WARMUP);
  localparam logic [1:0]       CH_INIT_C   = 2'(CHOOSER_INIT);

  pred_state_e      state_q, state_d;
  logic [CNT_W-1:0] sample_q, sample_d;
  logic [1:0]       chooser_q, chooser_d;
  logic [CNT_W-1:0] sample_inc;
  logic             clear_cnt;
  logic             score;
  logic             y_ok, z_ok, t_ok;
  logic             sel_z;
  logic             pred;

  assign y_ok       = (bus.y_pred == bus.x);
  assign z_ok       = (bus.z_pred == bus.x);
  assign sel_z      = chooser_q[1];
  assign pred       = sel_z ? bus.z_pred : bus.y_pred;
  assign t_ok       = (pred == bus.x);
  assign sample_inc = sample_q + CNT_W'(1);

  // FSM, sample count and chooser registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sample_q  <= '0;
      chooser_q <= CH_INIT_C;
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      chooser_q <= chooser_d;
    end
  end

  // Next-state logic: epoch start, warm-up counting, scored run, completion.
  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    chooser_d = chooser_q;
    clear_cnt = 1'b0;
    score     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          clear_cnt = 1'b1;
          sample_d  = '0;
          chooser_d = CH_INIT_C;
          state_d   = (WARMUP == 0) ? RUN : WARM;
        end
      end
      WARM: begin
        if (bus.x_valid) begin
          sample_d = sample_inc;
          if (sample_inc == WARMUP_C) state_d = RUN;
        end
      end
      RUN: begin
        if (bus.x_valid) begin
          sample_d  = sample_inc;
          score     = 1'b1;
          chooser_d = chooser_next(chooser_q, y_ok, z_ok);
          if (sample_inc == EPOCH_LEN_C) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_y_cnt (
    .clk(clk), .reset(reset), .clear(clear_cnt), .inc(score && y_ok), .count(bus.y_cnt)
  );
  sat_counter #(.W(CNT_W)) u_z_cnt (
    .clk(clk), .reset(reset), .clear(clear_cnt), .inc(score && z_ok), .count(bus.z_cnt)
  );
  sat_counter #(.W(CNT_W)) u_t_cnt (
    .clk(clk), .reset(reset), .clear(clear_cnt), .inc(score && t_ok), .count(bus.t_cnt)
  );
`ifdef PRED_CTRL_DISAGREE_CNT_EN
  sat_counter #(.W(CNT_W)) u_disagree_cnt (
    .clk(clk), .reset(reset), .clear(clear_cnt),
    .inc(score && (bus.y_pred != bus.z_pred)), .count(bus.disagree_cnt)
  );
`endif

  assign bus.pred_out   = pred;
  assign bus.sel_z      = sel_z;
  assign bus.chooser    = chooser_q;
  assign bus.busy       = (state_q == WARM) || (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.sample_cnt = sample_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_pred_tournament_ctrl.sv
// Directed bench for pred_tournament_ctrl: default build (36/4/8) plus a
// small build (CNT_W=4, EPOCH_LEN=15, WARMUP=0) for the counter ceiling.
module tb_pred_tournament_ctrl;
  import pred_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  pred_tournament_ctrl_if #(.CNT_W(8)) bus8 ();
  pred_tournament_ctrl_if #(.CNT_W(4)) bus4 ();

  pred_tournament_ctrl #(.CNT_W(8), .EPOCH_LEN(36), .WARMUP(4), .CHOOSER_INIT(1)) dut (
    .clk(clk), .reset(reset), .bus(bus8)
  );
  pred_tournament_ctrl #(.CNT_W(4), .EPOCH_LEN(15), .WARMUP(0), .CHOOSER_INIT(1)) dut_s (
    .clk(clk), .reset(reset), .bus(bus4)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drivers: inputs change on the falling edge, checks follow #1 later.
  task automatic send(input logic xv, input logic yv, input logic zv);
    @(negedge clk);
    bus8.start   = 1'b0;
    bus8.x_valid = 1'b1;
    bus8.x       = xv;
    bus8.y_pred  = yv;
    bus8.z_pred  = zv;
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus8.start   = 1'b0;
    bus8.x_valid = 1'b0;
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus8.start   = 1'b1;
    bus8.x_valid = 1'b0;
    #1;
  endtask

  logic [35:0] pat;
  logic [1:0]  exp_ch [3];
  logic        exp_sel[3];
  logic        xb;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    bus8.start = 1'b0; bus8.x_valid = 1'b0; bus8.x = 1'b0; bus8.y_pred = 1'b0; bus8.z_pred = 1'b0;
    bus4.start = 1'b0; bus4.x_valid = 1'b0; bus4.x = 1'b0; bus4.y_pred = 1'b0; bus4.z_pred = 1'b0;
    pat = 36'b000011111111000011110000000011110000;
    exp_ch[0] = 2'd1; exp_ch[1] = 2'd2; exp_ch[2] = 2'd3;
    exp_sel[0] = 1'b0; exp_sel[1] = 1'b1; exp_sel[2] = 1'b1;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_chooser", bus8.chooser, 1);
    chk("rst_sel_z", bus8.sel_z, 0);
    chk("rst_busy", bus8.busy, 0);
    chk("rst_done", bus8.done, 0);
    chk("rst_state", bus8.state, IDLE);
    chk("rst_y_cnt", bus8.y_cnt, 0);
    @(negedge clk);
    reset = 1'b1;

    // x_valid in IDLE is dropped.
    send(1'b1, 1'b1, 1'b0);
    idle();
    chk("idle_ign_sample", bus8.sample_cnt, 0);
    chk("idle_ign_state", bus8.state, IDLE);

    // Warm-up, then chooser walks toward Z.
    pulse_start();
    idle();
    chk("a_state_warm", bus8.state, WARM);
    chk("a_busy", bus8.busy, 1);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b1, 1'b0);
      chk("a_warm_chooser", bus8.chooser, 1);
    end
    for (int j = 0; j < 3; j++) begin
      send(1'b1, 1'b0, 1'b1);
      chk("a_run_state", bus8.state, RUN);
      chk("a_run_chooser", bus8.chooser, exp_ch[j]);
      chk("a_run_sel_z", bus8.sel_z, exp_sel[j]);
      chk("a_run_pred_out", bus8.pred_out, exp_sel[j]);
    end
    idle();
    chk("a_chooser_end", bus8.chooser, 3);
    chk("a_y_cnt", bus8.y_cnt, 0);
    chk("a_z_cnt", bus8.z_cnt, 3);
    chk("a_t_cnt", bus8.t_cnt, 2);
    chk("a_sample_cnt", bus8.sample_cnt, 7);

    // Reset mid-epoch aborts immediately.
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_z_cnt", bus8.z_cnt, 0);
    chk("mid_rst_t_cnt", bus8.t_cnt, 0);
    chk("mid_rst_sample", bus8.sample_cnt, 0);
    chk("mid_rst_chooser", bus8.chooser, 1);
    chk("mid_rst_sel_z", bus8.sel_z, 0);
    chk("mid_rst_busy", bus8.busy, 0);
    chk("mid_rst_state", bus8.state, IDLE);
    @(negedge clk);
    reset = 1'b1;

    // Full epoch with y always right, z always wrong, gaps and a stray start.
    pulse_start();
    for (int k = 0; k < 36; k++) begin
      xb = pat[35 - k];
      send(xb, xb, ~xb);
      if (k == 35) begin
        chk("b_done_before_last", bus8.done, 0);
        chk("b_busy_before_last", bus8.busy, 1);
      end
      if (k == 9) begin
        pulse_start();
        idle();
        chk("b_start_in_run_sample", bus8.sample_cnt, 10);
        chk("b_start_in_run_y_cnt", bus8.y_cnt, 6);
        chk("b_start_in_run_state", bus8.state, RUN);
      end else if ((k % 7) == 6) begin
        idle();
      end
    end
    idle();
    chk("b_done", bus8.done, 1);
    chk("b_busy", bus8.busy, 0);
    chk("b_sample_cnt", bus8.sample_cnt, 36);
    chk("b_y_cnt", bus8.y_cnt, 32);
    chk("b_z_cnt", bus8.z_cnt, 0);
    chk("b_t_cnt", bus8.t_cnt, 32);
    chk("b_chooser", bus8.chooser, 0);
`ifdef PRED_CTRL_DISAGREE_CNT_EN
    chk("b_disagree_cnt", bus8.disagree_cnt, 32);
`endif

    // 37th sample is ignored in DONE.
    send(1'b1, 1'b1, 1'b0);
    idle();
    chk("b_37th_sample", bus8.sample_cnt, 36);
    chk("b_37th_y_cnt", bus8.y_cnt, 32);
    chk("b_37th_state", bus8.state, DONE);

    // Start together with x_valid in DONE: only start acts.
    @(negedge clk);
    bus8.start = 1'b1; bus8.x_valid = 1'b1; bus8.x = 1'b1; bus8.y_pred = 1'b1; bus8.z_pred = 1'b1;
    idle();
    chk("c_restart_sample", bus8.sample_cnt, 0);
    chk("c_restart_y_cnt", bus8.y_cnt, 0);
    chk("c_restart_t_cnt", bus8.t_cnt, 0);
    chk("c_restart_chooser", bus8.chooser, 1);
    chk("c_restart_state", bus8.state, WARM);
`ifdef PRED_CTRL_DISAGREE_CNT_EN
    chk("c_restart_disagree", bus8.disagree_cnt, 0);
`endif

    // Small build: no warm-up, counters reach their ceiling.
    @(negedge clk);
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    #1;
    chk("s_state_run", bus4.state, RUN);
    for (int m = 0; m < 15; m++) begin
      @(negedge clk);
      xb = 1'($urandom_range(0, 1));
      bus4.x_valid = 1'b1; bus4.x = xb; bus4.y_pred = xb; bus4.z_pred = xb;
    end
    @(negedge clk);
    bus4.x_valid = 1'b0;
    #1;
    chk("s_y_cnt", bus4.y_cnt, 15);
    chk("s_z_cnt", bus4.z_cnt, 15);
    chk("s_t_cnt", bus4.t_cnt, 15);
    chk("s_sample_cnt", bus4.sample_cnt, 15);
    chk("s_chooser", bus4.chooser, 1);
    chk("s_done", bus4.done, 1);
    @(negedge clk);
    bus4.x_valid = 1'b1; bus4.x = 1'b1; bus4.y_pred = 1'b1; bus4.z_pred = 1'b1;
    @(negedge clk);
    bus4.x_valid = 1'b0;
    #1;
    chk("s_hold_y_cnt", bus4.y_cnt, 15);
    chk("s_hold_state", bus4.state, DONE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pred_tournament_ctrl.md
Name: pred_tournament_ctrl

Overview:
Sequencer and chooser for two pattern predictors (Y and Z) that both observe the same outcome stream X. It runs fixed-length evaluation epochs with a warm-up phase and picks the better predictor per sample using a 2-bit saturating chooser. It keeps per-predictor and tournament match counts, and sits between the outcome source and the predictor pair.

Parameters:
CNT_W, 8, width of all match and sample counters (saturating)
EPOCH_LEN, 36, valid samples per epoch, including warm-up
WARMUP, 4, leading samples of an epoch that update neither the chooser nor the match counters
CHOOSER_INIT, 1, chooser value loaded at reset and at each epoch start (0..3)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin an epoch; ignored while busy
x_valid  in  1  current x/y_pred/z_pred are a sample
x  in  1  actual outcome
y_pred  in  1  prediction from predictor Y for this sample
z_pred  in  1  prediction from predictor Z for this sample
pred_out  out  1  chosen prediction (combinational: sel_z ? z_pred : y_pred)
sel_z  out  1  chooser[1]; 1 means Z is selected
chooser  out  2  chooser state
busy  out  1  high in WARM and RUN
done  out  1  high in DONE
y_cnt  out  CNT_W  post-warm-up samples with y_pred==x
z_cnt  out  CNT_W  post-warm-up samples with z_pred==x
t_cnt  out  CNT_W  post-warm-up samples with pred_out==x
sample_cnt  out  CNT_W  valid samples accepted this epoch

Behaviour:
- Reset (reset=0, async): state=IDLE, chooser=CHOOSER_INIT, all counters 0, busy=0, done=0.
- States: IDLE, WARM, RUN, DONE.
  - IDLE: start -> WARM. Clear counters and load chooser=CHOOSER_INIT on the same edge.
  - WARM: each x_valid increments sample_cnt. When the accepted sample brings sample_cnt to WARMUP, go to RUN. If WARMUP=0, start goes directly to RUN.
  - RUN: each x_valid increments sample_cnt, updates y_cnt, z_cnt and t_cnt, and updates the chooser. The sample that brings sample_cnt to EPOCH_LEN moves the FSM to DONE.
  - DONE: counters hold. start -> WARM, clearing counters and reloading the chooser.
- x_valid in IDLE or DONE is ignored.
- start in WARM or RUN is ignored.
- start and x_valid in the same IDLE/DONE cycle: only start takes effect.
- Chooser update in RUN, per valid sample, using the pre-edge chooser value:
  - y correct and z wrong: decrement, saturating at 0.
  - z correct and y wrong: increment, saturating at 3.
  - both correct or both wrong: hold.
- Latency:
  - pred_out and sel_z reflect the chooser before the current sample's update.
  - Counter and chooser updates are visible one cycle after the x_valid edge.
  - done rises the cycle after the final sample.
- Saturation: every counter saturates at 2^CNT_W-1. sample_cnt saturation cannot occur for legal EPOCH_LEN (EPOCH_LEN < 2^CNT_W, checked by an elaboration assertion).
- Reset asserted mid-epoch aborts immediately to the reset values. No partial results are retained.

Optional Feature:
PRED_CTRL_DISAGREE_CNT_EN:
- Defined: adds output port disagree_cnt (CNT_W), counting post-warm-up valid samples with y_pred!=z_pred. It is saturating, cleared on reset and on epoch start, and held in DONE.
- Undefined: the port and its logic do not exist; all other behaviour is identical.

Decomposition:
- Package pred_ctrl_pkg holds:
  - state enum (IDLE, WARM, RUN, DONE);
  - chooser constants CH_STRONG_Y=0, CH_WEAK_Y=1, CH_WEAK_Z=2, CH_STRONG_Z=3;
  - function chooser_next(cur, y_ok, z_ok).
- Sub-module sat_counter (parameter W; inputs clear, inc; output count) is instantiated for y_cnt, z_cnt, t_cnt and, when enabled, disagree_cnt.

Test Plan:
- Reset: drive reset=0 mid-stream, then release -> all counters 0, chooser=1, sel_z=0, busy=0, done=0, state IDLE.
- Warm-up then chooser flip:
  - stimulus: start; 4 samples with y correct, z wrong; then 3 samples with z correct, y wrong.
  - chooser stays 1 through warm-up, then goes 2, 3, 3.
  - sel_z=1 from the 6th sample onward.
  - final counts: z_cnt=3, y_cnt=0, t_cnt=2.
- Epoch end:
  - stimulus: start, then 36 valid samples of pattern 000011111111000011110000000011110000 with y_pred=x and z_pred=~x, including x_valid gaps.
  - done=1 exactly one cycle after the 36th sample; sample_cnt=36, y_cnt=32, z_cnt=0, t_cnt=32, chooser=0.
  - the 37th x_valid is ignored.
- Saturation (CNT_W=4, EPOCH_LEN=15, WARMUP=0): 15 samples with both predictors correct -> y_cnt=z_cnt=t_cnt=15, chooser holds 1.
- Ignored controls: start pulsed during RUN -> no counter clear. start in DONE -> counters 0 and chooser=1 next cycle. With PRED_CTRL_DISAGREE_CNT_EN defined, the disagree_cnt after epoch-end run is 32.
